mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between an instruction-fetch port and a load/store port.
// The data side wins ties; a bounded counter of back-to-back data grants stops fetch from starving.
module mem_arbiter #(
    parameter int MAX_IF_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,

    input  logic        ds_req_i,
    input  logic        ds_we_i,
    input  logic [31:0] ds_addr_i,
    input  logic [31:0] ds_wdata_i,
    output logic        ds_ack_o,
    output logic [31:0] ds_rdata_o,

    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,

    output logic        stall_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] WAIT_MAX = 3'(MAX_IF_WAIT);

    logic [1:0]  state;
    logic [2:0]  wait_cnt;
    logic        sel_ds;
    logic [31:0] rdata_q;

    logic        fetch_due;
    logic        grant_ds;
    logic        grant_if;

    // Grant decision is only meaningful in IDLE; requests seen in BUSY/RESP are ignored.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        fetch_due = 1'b0;
        grant_ds  = 1'b0;
        grant_if  = 1'b0;
        if (state == ST_IDLE) begin
            fetch_due = if_req_i && (wait_cnt == WAIT_MAX);
            grant_ds  = ds_req_i && !fetch_due;
            grant_if  = if_req_i && !grant_ds;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= 3'd0;
            sel_ds      <= 1'b0;
            rdata_q     <= 32'd0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_ds) begin
                        state       <= ST_BUSY;
                        sel_ds      <= 1'b1;
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= ds_we_i;
                        mem_addr_o  <= ds_addr_i;
                        mem_wdata_o <= ds_wdata_i;
                        // Count only grants that actually made a waiting fetch wait longer.
                        if (if_req_i && (wait_cnt < WAIT_MAX)) begin
                            wait_cnt <= wait_cnt + 3'd1;
                        end
                    end else if (grant_if) begin
                        state       <= ST_BUSY;
                        sel_ds      <= 1'b0;
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= 32'd0;
                        wait_cnt    <= 3'd0;
                    end
                end

                ST_BUSY: begin
                    if (mem_ready_i) begin
                        state       <= ST_RESP;
                        rdata_q     <= mem_we_o ? 32'd0 : mem_rdata_i;
                        mem_en_o    <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= 32'd0;
                        mem_wdata_o <= 32'd0;
                    end
                end

                ST_RESP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_ack_o   = (state == ST_RESP) && !sel_ds;
    assign ds_ack_o   = (state == ST_RESP) &&  sel_ds;
    assign if_rdata_o = if_ack_o ? rdata_q : 32'd0;
    assign ds_rdata_o = ds_ack_o ? rdata_q : 32'd0;

    assign stall_o = (if_req_i && !if_ack_o) || (ds_req_i && !ds_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter; expected grants come from a
// transaction-level model of the arbitration rule with an integer starvation count.
module tb_mem_arbiter;

    localparam int MAX_IF_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        ds_req = 1'b0;
    logic        ds_we = 1'b0;
    logic [31:0] ds_addr = '0;
    logic [31:0] ds_wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    logic        if_ack, ds_ack, mem_en, mem_we, stall;
    logic [31:0] if_rdata, ds_rdata, mem_addr, mem_wdata;

    int checks = 0;
    int failures = 0;

    // Reference model state: starvation count plus the transaction expected on the memory port.
    int          model_wait = 0;
    logic        exp_ds;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;

    int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    mem_arbiter #(.MAX_IF_WAIT(MAX_IF_WAIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_ack_o    (if_ack),
        .if_rdata_o  (if_rdata),
        .ds_req_i    (ds_req),
        .ds_we_i     (ds_we),
        .ds_addr_i   (ds_addr),
        .ds_wdata_i  (ds_wdata),
        .ds_ack_o    (ds_ack),
        .ds_rdata_o  (ds_rdata),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ready_i (mem_ready),
        .stall_o     (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic en, input logic ai, input logic ad,
                             input logic [31:0] ri, input logic [31:0] rd);
        logic exp_stall;
        exp_stall = (if_req & ~ai) | (ds_req & ~ad);
        check({tag, ".mem_en"},   {31'd0, mem_en}, {31'd0, en});
        check({tag, ".if_ack"},   {31'd0, if_ack}, {31'd0, ai});
        check({tag, ".ds_ack"},   {31'd0, ds_ack}, {31'd0, ad});
        check({tag, ".if_rdata"}, if_rdata, ri);
        check({tag, ".ds_rdata"}, ds_rdata, rd);
        check({tag, ".stall"},    {31'd0, stall}, {31'd0, exp_stall});
    endtask

    task automatic check_mem(input string tag);
        check({tag, ".mem_we"},    {31'd0, mem_we}, {31'd0, exp_we});
        check({tag, ".mem_addr"},  mem_addr, exp_addr);
        check({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
    endtask

    // Arbitration rule: data wins unless fetch has already waited MAX_IF_WAIT data grants.
    task automatic arbitrate();
        if (ds_req && !(if_req && model_wait == MAX_IF_WAIT)) begin
            exp_ds    = 1'b1;
            exp_we    = ds_we;
            exp_addr  = ds_addr;
            exp_wdata = ds_wdata;
            if (if_req && model_wait < MAX_IF_WAIT) model_wait++;
        end else begin
            exp_ds    = 1'b0;
            exp_we    = 1'b0;
            exp_addr  = if_addr;
            exp_wdata = 32'd0;
            model_wait = 0;
        end
    endtask

    task automatic grant_step(input string tag);
        arbitrate();
        tick();
        check_out({tag, ".grant"}, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        check_mem({tag, ".grant"});
    endtask

    // Memory answers in BUSY cycle d (d=1 means ready in the first BUSY cycle).
    task automatic serve(input string tag, input int d, input logic [31:0] rd);
        logic [31:0] exp_rd;
        for (int i = 1; i <= d; i++) begin
            mem_ready = (i == d);
            mem_rdata = (i == d) ? rd : $urandom;
            tick();
            if (i < d) begin
                check_out({tag, ".busy"}, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
                check_mem({tag, ".busy"});
            end
        end
        exp_rd = exp_we ? 32'd0 : rd;
        if (exp_ds) check_out({tag, ".resp"}, 1'b0, 1'b0, 1'b1, 32'd0, exp_rd);
        else        check_out({tag, ".resp"}, 1'b0, 1'b1, 1'b0, exp_rd, 32'd0);
    endtask

    // The RESP cycle: memory noise must not matter and the ack must not repeat.
    task automatic finish_resp(input string tag);
        mem_ready = 1'b1;
        mem_rdata = $urandom;
        tick();
        mem_ready = 1'b0;
        check_out({tag, ".after"}, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        model_wait = 0;
    endtask

    task automatic run_both(input string tag, input int n);
        if_req = 1'b1;
        ds_req = 1'b1;
        ds_we  = 1'b0;
        for (int g = 0; g < n; g++) begin
            grant_step(tag);
            serve(tag, 1, $urandom);
            check({tag, ".order"}, {31'd0, ds_ack}, exp_order[g]);
            finish_resp(tag);
        end
    endtask

    initial begin
        // Reset state, with stall still following the requests.
        #2;
        check_out("reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("reset.mem_addr", mem_addr, 32'd0);
        ds_req = 1'b1;
        #1;
        check("reset.stall_comb", {31'd0, stall}, 32'd1);
        ds_req = 1'b0;
        tick();
        check_out("reset.edge", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #2;
        rst = 1'b1;

        // Idle with memory noise only.
        mem_ready = 1'b1;
        tick();
        check_out("idle_ready", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        mem_ready = 1'b0;

        // Single fetch, memory answers in the first BUSY cycle.
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        #1;
        check("fetch.stall_pre", {31'd0, stall}, 32'd1);
        grant_step("fetch");
        serve("fetch", 1, 32'hDEAD_BEEF);
        if_req = 1'b0;
        finish_resp("fetch");

        // Store with the memory holding off for three BUSY cycles.
        ds_req   = 1'b1;
        ds_we    = 1'b1;
        ds_addr  = 32'h0000_0100;
        ds_wdata = 32'h1234_5678;
        grant_step("store");
        serve("store", 3, 32'hCAFE_F00D);
        ds_req = 1'b0;
        finish_resp("store");

        // Both requesters held high: four data grants, then fetch, repeated.
        apply_reset();
        if_addr  = 32'h0000_0A00;
        ds_addr  = 32'h0000_0B00;
        ds_wdata = 32'h5555_AAAA;
        run_both("both", 10);
        if_req = 1'b0;
        ds_req = 1'b0;

        // Fetch withdrawn before the grant edge: data wins and the count stays at zero.
        apply_reset();
        if_req = 1'b1;
        ds_req = 1'b1;
        ds_we  = 1'b0;
        #2;
        if_req = 1'b0;
        grant_step("withdraw");
        serve("withdraw", 2, 32'h0BAD_F00D);
        finish_resp("withdraw");
        run_both("post_withdraw", 5);
        if_req = 1'b0;
        ds_req = 1'b0;

        // Reset mid-BUSY: transaction abandoned, pending fetch granted right after release.
        tick();
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        grant_step("rst_busy");
        mem_ready = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check_out("rst_busy.async", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("rst_busy.mem_addr", mem_addr, 32'd0);
        model_wait = 0;
        mem_ready = 1'b1;
        tick();
        check_out("rst_busy.held", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        mem_ready = 1'b0;
        #3;
        rst = 1'b1;
        grant_step("rst_release");
        serve("rst_release", 1, 32'h7777_0001);
        if_req = 1'b0;
        finish_resp("rst_release");

        // Randomized traffic against the model.
        for (int t = 0; t < 60; t++) begin
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_req  = 1'b1;
                if_addr = $urandom;
            end
            if (!ds_req && $urandom_range(0, 1) == 1) begin
                ds_req   = 1'b1;
                ds_we    = 1'($urandom_range(0, 1));
                ds_addr  = $urandom;
                ds_wdata = $urandom;
            end
            if (!if_req && !ds_req) begin
                mem_ready = 1'($urandom_range(0, 1));
                tick();
                check_out("rnd.idle", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
                mem_ready = 1'b0;
                ds_req   = 1'b1;
                ds_we    = 1'($urandom_range(0, 1));
                ds_addr  = $urandom;
                ds_wdata = $urandom;
            end
            grant_step("rnd");
            serve("rnd", $urandom_range(1, 4), $urandom);
            if (exp_ds) ds_req = 1'b0;
            else        if_req = 1'b0;
            finish_resp("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
